// File: rtl/fetch_pkg.sv
// Fetch sequencer shared types: FSM state encoding, PC step and default reset address.
// No logic of its own; latency and backpressure are owned by fetch_ctrl.
// Imported by fetch_pc_sel and fetch_ctrl.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0030;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC select: branch target over jump target over sequential pc+4.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the selected value is taken.
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output logic [31:0] next_pc
);

    assign redirect = branch_taken | jump;

    // EX-stage branch is older than the ID-stage jump, so it wins.
    assign next_pc = branch_taken ? branch_target :
                     jump         ? jump_target   :
                                    pc + PC_INC;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC and imem request; ack in cycle N gives valid_f in N+1.
// A stalled IF/ID slot parks one word in a hold buffer and drops imem_req until decode drains.
// Optional ack-wait timeout with sticky fetch_err under macro FETCH_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallf,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic        valid_f,
    output logic        fetch_err
);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] hold_pc;
    logic [31:0] redir_pc;
    logic        redirect;
    logic [31:0] next_pc;
    logic        slot_free;
    logic        timeout;

    fetch_pc_sel u_pc_sel (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .next_pc       (next_pc)
    );

    assign imem_addr = pc;
    assign slot_free = !valid_f || !stallf;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    assign timeout = imem_req && !imem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (!imem_req || imem_ack || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                fetch_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            hold_buf <= '0;
            hold_pc  <= '0;
            redir_pc <= '0;
            instr_f  <= '0;
            pc_f     <= '0;
            valid_f  <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            // Consumed or wrong-path slot empties unless a new word lands below.
            if (redirect || (valid_f && !stallf))
                valid_f <= 1'b0;

            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (timeout) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                        if (redirect)
                            pc <= next_pc;
                    end else if (imem_ack) begin
                        if (redirect) begin
                            pc <= next_pc;
                        end else if (slot_free) begin
                            instr_f <= imem_rdata;
                            pc_f    <= pc;
                            valid_f <= 1'b1;
                            pc      <= next_pc;
                        end else begin
                            hold_buf <= imem_rdata;
                            hold_pc  <= pc;
                            pc       <= next_pc;
                            state    <= S_HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request address must stay stable until the ack arrives.
                        redir_pc <= next_pc;
                        state    <= S_KILL;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc       <= next_pc;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else if (!stallf) begin
                        instr_f  <= hold_buf;
                        pc_f     <= hold_pc;
                        valid_f  <= 1'b1;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_KILL: begin
                    if (redirect)
                        redir_pc <= next_pc;
                    if (imem_ack || timeout) begin
                        pc       <= redirect ? next_pc : redir_pc;
                        state    <= timeout ? S_IDLE : S_FETCH;
                        imem_req <= !timeout;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a transaction-level model predicts port state and decode transfers,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0040_0030;
    localparam int          TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallf = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic        valid_f;
    logic        fetch_err;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .stallf        (stallf),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .valid_f       (valid_f),
        .fetch_err     (fetch_err)
    );

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic        err;
    } port_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } xfer_t;

    port_t port_q[$];
    xfer_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_en = 1'b0;

    // Reference model: the address stream and the words decode should see.
    bit          m_start, m_req, m_wrong, m_held, m_sv, m_err;
    logic [31:0] m_addr, m_redir, m_hd, m_hp;
    int          m_wait;

    task automatic chk(input string name, input logic [98:0] act, input logic [98:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_start = 1; m_req = 0; m_wrong = 0; m_held = 0; m_sv = 0; m_err = 0;
        m_addr = RPC; m_redir = '0; m_hd = '0; m_hp = '0; m_wait = 0;
        port_q.delete();
        exp_q.delete();
    endtask

    task automatic load_slot(input logic [31:0] p, input logic [31:0] w);
        xfer_t x;
        m_sv = 1;
        x.pc = p; x.ins = w;
        exp_q.push_back(x);
    endtask

    // Called right after a posedge: records expected port state, drives one cycle, advances the model.
    task automatic step(input bit st, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt, input bit ak);
        port_t       p;
        bit          redir, xfer, free, ackd, timed_out;
        logic [31:0] tgt, rd;
        p.req = m_req; p.addr = m_addr; p.vld = m_sv; p.err = m_err;
        port_q.push_back(p);
        redir = br | jp;
        tgt   = br ? bt : jt;
        ackd  = ak & m_req;
        rd    = $urandom;
        stallf = st; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; imem_ack = ackd; imem_rdata = rd;

        xfer = m_sv & !st;
        free = !m_sv | !st;
        timed_out = 0;
`ifdef FETCH_TIMEOUT_EN
        if (m_req && !ackd) begin
            m_wait++;
            if (m_wait == TMO) begin timed_out = 1; m_wait = 0; end
        end else begin
            m_wait = 0;
        end
`endif
        // A squashed word that decode never accepted must not be expected.
        if (m_sv && !xfer && redir) void'(exp_q.pop_back());
        if (xfer || redir) m_sv = 0;

        if (m_start) begin
            m_start = 0; m_req = 1;
        end else if (m_held) begin
            if (redir) begin
                m_held = 0; m_addr = tgt; m_req = 1;
            end else if (!st) begin
                load_slot(m_hp, m_hd); m_held = 0; m_req = 1;
            end
        end else if (m_req) begin
            if (timed_out) begin
                m_err = 1; m_req = 0; m_start = 1;
                if (redir) m_addr = tgt;
                else if (m_wrong) m_addr = m_redir;
                m_wrong = 0;
            end else if (ackd) begin
                if (redir) m_addr = tgt;
                else if (m_wrong) m_addr = m_redir;
                else if (free) begin load_slot(m_addr, rd); m_addr = m_addr + 32'd4; end
                else begin
                    m_held = 1; m_hd = rd; m_hp = m_addr; m_addr = m_addr + 32'd4; m_req = 0;
                end
                m_wrong = 0;
            end else if (redir) begin
                m_wrong = 1; m_redir = tgt;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        stallf = 0; branch_taken = 0; jump = 0; imem_ack = 0;
        #2 rst = 1'b1;
        #1 chk("async_reset", {imem_req, valid_f, fetch_err, imem_addr, instr_f, pc_f},
               {3'b000, RPC, 64'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            port_t e;
            xfer_t x;
            if (port_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL port_underflow no expected entry at %0t", $time);
            end else begin
                e = port_q.pop_front();
                chk("port_state",
                    {imem_req, (imem_req ? imem_addr : 32'h0), valid_f, fetch_err},
                    {e.req, (e.req ? e.addr : 32'h0), e.vld, e.err});
            end
            if (valid_f && !stallf) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL xfer_unexpected pc_f=%h instr_f=%h at %0t", pc_f, instr_f, $time);
                end else begin
                    x = exp_q.pop_front();
                    chk("xfer", {pc_f, instr_f}, {x.pc, x.ins});
                end
            end
        end
    end

    initial begin
        bit          st, br, jp, ak;
        logic [31:0] bt, jt;
        do_reset();

        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
        // stall with a live word: next ack parks in the hold buffer
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // jump while waiting for ack
        step(0, 0, 0, 1, 32'h0040_0100, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // branch and jump together
        step(0, 1, 32'h0040_0200, 1, 32'h0040_0300, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // pc wrap
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // reset while a request is outstanding
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset();
        // long ack drought
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        // kill path under a drought, with a second redirect overwriting the first
        step(0, 0, 0, 1, 32'h0000_1000, 0);
        step(0, 1, 32'h0000_2002, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(9) < 3);
            br = ($urandom_range(19) == 0);
            jp = ($urandom_range(19) == 0);
            bt = $urandom;
            jt = $urandom;
            ak = ($urandom_range(9) < 6);
            if ($urandom_range(499) == 0) do_reset();
            else step(st, br, bt, jp, jt, ak);
        end

        mon_en = 0;
        if (port_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL port_leftover %0d entries not checked", port_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
